multi_push_multi_pop_fifo_flags: RTL

Parametrised successor to the multi-push/multi-pop FIFO. Each cycle it accepts 0..N entries and releases 0..N entries. Depth does not have to be a power of two. On top of the basic FIFO it adds an occupancy output, almost-full and almost-empty thresholds, a synchronous flush, and optional sticky overflow/underflow error detection. It sits between the UART byte stream and the multi-sample FFT input packer, where bursts of several samples per cycle are pushed or popped.

---
 rtl/multi_push_multi_pop_fifo_flags.sv | 120 ++++++++++++
 1 files changed

// File: rtl/multi_push_multi_pop_fifo_flags.sv
// rtl/multi_push_multi_pop_fifo_flags.sv - multi-push/multi-pop FIFO with level, thresholds, flush
// Define MPMP_FIFO_ERR_EN to drop illegal requests and raise sticky err_ovf/err_udf; otherwise requests are clamped.
module multi_push_multi_pop_fifo_flags #(
  parameter int W     = 8,
  parameter int D     = 9,
  parameter int N     = 4,
  parameter int AF_TH = D - N,
  parameter int AE_TH = N,
  parameter int WN    = $clog2(N + 1) + 1,
  parameter int WL    = $clog2(D + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [WN-1:0]       push,
  input  logic [N-1:0][W-1:0] push_data,
  input  logic [WN-1:0]       pop,
  output logic [N-1:0][W-1:0] pop_data,
  output logic [WN-1:0]       can_push,
  output logic [WN-1:0]       can_pop,
  output logic [WL-1:0]       level,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                err_ovf,
  output logic                err_udf,
  input  logic                err_clr
);

  localparam int PW = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]  mem [D];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [WN-1:0] push_eff;
  logic [WN-1:0] pop_eff;
  logic [WL-1:0] level_next;

  // k never exceeds N <= D, so a single subtraction wraps the index.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= D) s = s - D;
    return PW'(s);
  endfunction

  always_comb begin
    int room;
    room         = D - int'(level);
    can_push     = WN'((room < N) ? room : N);
    can_pop      = WN'((int'(level) < N) ? int'(level) : N);
    almost_full  = (int'(level) >= AF_TH);
    almost_empty = (int'(level) <= AE_TH);
  end

`ifdef MPMP_FIFO_ERR_EN
  logic ovf_req;
  logic udf_req;

  always_comb begin
    ovf_req  = (push > can_push);
    udf_req  = (pop > can_pop);
    push_eff = ovf_req ? '0 : push;
    pop_eff  = udf_req ? '0 : pop;
  end

  // Flush leaves the flags alone; a violation on the err_clr edge still sets them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      err_ovf <= (err_ovf & ~err_clr) | (ovf_req & ~flush);
      err_udf <= (err_udf & ~err_clr) | (udf_req & ~flush);
    end
  end
`else
  logic unused_err_clr;

  always_comb begin
    push_eff = (push > can_push) ? can_push : push;
    pop_eff  = (pop > can_pop) ? can_pop : pop;
  end

  assign err_ovf        = 1'b0;
  assign err_udf        = 1'b0;
  assign unused_err_clr = err_clr;
`endif

  assign level_next = WL'(int'(level) + int'(push_eff) - int'(pop_eff));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= ptr_add(wr_ptr, int'(push_eff));
      rd_ptr <= ptr_add(rd_ptr, int'(pop_eff));
      level  <= level_next;
    end
  end

  // Storage carries no reset; only the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int i = 0; i < N; i++) begin
        if (i < int'(push_eff)) mem[ptr_add(wr_ptr, i)] <= push_data[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) pop_data[i] = mem[ptr_add(rd_ptr, i)];
  end

endmodule
